// File: rtl/matmul_addr_seq.sv
// Loop-nest address sequencer for D = A x B: emits one (a, b, d) address triple per MAC step.
// Multiplies happen only in SETUP; the RUN datapath is adders and counters.
module matmul_addr_seq #(
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned DIM_W  = 8,
    parameter int unsigned NCORES = 1,
    parameter int unsigned CID_W  = 1
) (
    input  logic              clock,
    input  logic              RST,
    input  logic              start,
    input  logic [DIM_W-1:0]  dim_i,
    input  logic [DIM_W-1:0]  dim_j,
    input  logic [DIM_W-1:0]  dim_k,
    input  logic [ADDR_W-1:0] base_a,
    input  logic [ADDR_W-1:0] base_b,
    input  logic [ADDR_W-1:0] base_d,
    input  logic              b_trans,
    input  logic [CID_W-1:0]  core_id,
    input  logic              addr_ready,
    output logic              addr_valid,
    output logic [ADDR_W-1:0] addr_a,
    output logic [ADDR_W-1:0] addr_b,
    output logic [ADDR_W-1:0] addr_d,
    output logic              first_k,
    output logic              last_k,
    output logic              busy,
    output logic              done
);

    localparam int unsigned CntW = DIM_W + 1;
    localparam int unsigned CmpW = (CID_W > DIM_W) ? CID_W : DIM_W;

    typedef enum logic [1:0] {StIdle, StSetup, StRun, StDone} state_e;

    state_e state_q, state_d;

    logic [DIM_W-1:0]  dim_i_q, dim_j_q, dim_k_q;
    logic [ADDR_W-1:0] base_a_q, base_b_q, base_d_q;
    logic              b_trans_q;
    logic [CID_W-1:0]  core_id_q;
    logic [ADDR_W-1:0] a_step_q, d_step_q, bk_step_q, bj_step_q;
    logic [DIM_W-1:0]  i_q, j_q, k_q;
    logic [ADDR_W-1:0] a_row_q, d_row_q, b_col_q;
    logic [ADDR_W-1:0] addr_a_q, addr_b_q, addr_d_q;

    logic              empty_job, last_k_w, last_j_w, last_i_w, final_beat;
    logic [CntW-1:0]   i_next;
    logic [ADDR_W-1:0] setup_a_row, setup_d_row;

    always_comb begin
        last_k_w    = (k_q == dim_k_q - DIM_W'(1));
        last_j_w    = (j_q == dim_j_q - DIM_W'(1));
        // Row counter is widened so that i + NCORES cannot wrap past I.
        i_next      = {1'b0, i_q} + CntW'(NCORES);
        last_i_w    = (i_next >= {1'b0, dim_i_q});
        final_beat  = addr_ready && last_k_w && last_j_w && last_i_w;
        empty_job   = (dim_i_q == '0) || (dim_j_q == '0) || (dim_k_q == '0) ||
                      (CmpW'(core_id_q) >= CmpW'(dim_i_q));
        setup_a_row = base_a_q + ADDR_W'(core_id_q) * ADDR_W'(dim_k_q);
        setup_d_row = base_d_q + ADDR_W'(core_id_q) * ADDR_W'(dim_j_q);
    end

    always_ff @(posedge clock or posedge RST) begin
        if (RST) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (start) state_d = StSetup;
            StSetup: state_d = empty_job ? StDone : StRun;
            StRun:   if (final_beat) state_d = StDone;
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        addr_valid = (state_q == StRun);
        busy       = (state_q == StSetup) || (state_q == StRun);
        done       = (state_q == StDone);
        addr_a     = addr_valid ? addr_a_q : '0;
        addr_b     = addr_valid ? addr_b_q : '0;
        addr_d     = addr_valid ? addr_d_q : '0;
        first_k    = addr_valid && (k_q == '0);
        last_k     = addr_valid && last_k_w;
    end

    always_ff @(posedge clock or posedge RST) begin
        if (RST) begin
            dim_i_q   <= '0;
            dim_j_q   <= '0;
            dim_k_q   <= '0;
            base_a_q  <= '0;
            base_b_q  <= '0;
            base_d_q  <= '0;
            b_trans_q <= 1'b0;
            core_id_q <= '0;
            a_step_q  <= '0;
            d_step_q  <= '0;
            bk_step_q <= '0;
            bj_step_q <= '0;
            i_q       <= '0;
            j_q       <= '0;
            k_q       <= '0;
            a_row_q   <= '0;
            d_row_q   <= '0;
            b_col_q   <= '0;
            addr_a_q  <= '0;
            addr_b_q  <= '0;
            addr_d_q  <= '0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (start) begin
                        dim_i_q   <= dim_i;
                        dim_j_q   <= dim_j;
                        dim_k_q   <= dim_k;
                        base_a_q  <= base_a;
                        base_b_q  <= base_b;
                        base_d_q  <= base_d;
                        b_trans_q <= b_trans;
                        core_id_q <= core_id;
                    end
                end
                StSetup: begin
                    a_step_q  <= ADDR_W'(NCORES) * ADDR_W'(dim_k_q);
                    d_step_q  <= ADDR_W'(NCORES) * ADDR_W'(dim_j_q);
                    // Transposed B walks k contiguously; row-major B walks k by a whole row.
                    bk_step_q <= b_trans_q ? ADDR_W'(1) : ADDR_W'(dim_j_q);
                    bj_step_q <= b_trans_q ? ADDR_W'(dim_k_q) : ADDR_W'(1);
                    i_q       <= DIM_W'(core_id_q);
                    j_q       <= '0;
                    k_q       <= '0;
                    a_row_q   <= setup_a_row;
                    d_row_q   <= setup_d_row;
                    b_col_q   <= base_b_q;
                    addr_a_q  <= setup_a_row;
                    addr_b_q  <= base_b_q;
                    addr_d_q  <= setup_d_row;
                end
                StRun: begin
                    if (addr_ready) begin
                        if (!last_k_w) begin
                            k_q      <= k_q + DIM_W'(1);
                            addr_a_q <= addr_a_q + ADDR_W'(1);
                            addr_b_q <= addr_b_q + bk_step_q;
                        end else if (!last_j_w) begin
                            k_q      <= '0;
                            j_q      <= j_q + DIM_W'(1);
                            addr_a_q <= a_row_q;
                            addr_d_q <= addr_d_q + ADDR_W'(1);
                            b_col_q  <= b_col_q + bj_step_q;
                            addr_b_q <= b_col_q + bj_step_q;
                        end else begin
                            k_q      <= '0;
                            j_q      <= '0;
                            i_q      <= i_next[DIM_W-1:0];
                            a_row_q  <= a_row_q + a_step_q;
                            d_row_q  <= d_row_q + d_step_q;
                            addr_a_q <= a_row_q + a_step_q;
                            addr_d_q <= d_row_q + d_step_q;
                            b_col_q  <= base_b_q;
                            addr_b_q <= base_b_q;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_matmul_addr_seq.sv
// Bench for matmul_addr_seq: table of jobs run against a loop-nest reference model,
// with beats compared through a scoreboard queue, plus a mid-run reset sequence.
`timescale 1ns/1ps
module tb_matmul_addr_seq;

    logic       clock = 1'b0;
    logic       RST, start, sel, b_trans, addr_ready;
    logic [7:0] dim_i, dim_j, dim_k, base_a, base_b, base_d;
    logic [0:0] core_id;
    logic       start1, start2;

    logic       v1, fk1, lk1, busy1, done1, v2, fk2, lk2, busy2, done2;
    logic [7:0] a1, b1, d1, a2, b2, d2;
    logic       o_v, o_fk, o_lk, o_busy, o_done;
    logic [7:0] o_a, o_b, o_d;

    always #5 clock = ~clock;

    assign start1 = start & ~sel;
    assign start2 = start & sel;
    assign o_v    = sel ? v2 : v1;
    assign o_a    = sel ? a2 : a1;
    assign o_b    = sel ? b2 : b1;
    assign o_d    = sel ? d2 : d1;
    assign o_fk   = sel ? fk2 : fk1;
    assign o_lk   = sel ? lk2 : lk1;
    assign o_busy = sel ? busy2 : busy1;
    assign o_done = sel ? done2 : done1;

    matmul_addr_seq u_dut (
        .clock(clock), .RST(RST), .start(start1), .dim_i(dim_i), .dim_j(dim_j),
        .dim_k(dim_k), .base_a(base_a), .base_b(base_b), .base_d(base_d),
        .b_trans(b_trans), .core_id(core_id), .addr_ready(addr_ready),
        .addr_valid(v1), .addr_a(a1), .addr_b(b1), .addr_d(d1), .first_k(fk1),
        .last_k(lk1), .busy(busy1), .done(done1)
    );

    matmul_addr_seq #(.NCORES(2), .CID_W(1)) u_dut2 (
        .clock(clock), .RST(RST), .start(start2), .dim_i(dim_i), .dim_j(dim_j),
        .dim_k(dim_k), .base_a(base_a), .base_b(base_b), .base_d(base_d),
        .b_trans(b_trans), .core_id(core_id), .addr_ready(addr_ready),
        .addr_valid(v2), .addr_a(a2), .addr_b(b2), .addr_d(d2), .first_k(fk2),
        .last_k(lk2), .busy(busy2), .done(done2)
    );

    typedef struct {
        logic [7:0] a, b, d;
        logic       fk, lk;
    } beat_t;

    // sel picks the NCORES=2 instance; stall_at is a 0-based beat index (-1: none).
    typedef struct {
        int sel, i, j, k, ba, bb, bd, bt, cid, stall_at, stall_len, pulse_at, exp_beats, exp_lat;
    } vec_t;

    beat_t exp_q[$];
    vec_t  vecs[12];
    int    tests = 0;
    int    fails = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    task automatic push_model(input vec_t t);
        int    nc;
        beat_t e;
        nc = (t.sel != 0) ? 2 : 1;
        for (int i = t.cid; i < t.i; i += nc)
            for (int j = 0; j < t.j; j++)
                for (int k = 0; k < t.k; k++) begin
                    e.a  = 8'(t.ba + i * t.k + k);
                    e.b  = (t.bt != 0) ? 8'(t.bb + j * t.k + k) : 8'(t.bb + k * t.j + j);
                    e.d  = 8'(t.bd + i * t.j + j);
                    e.fk = (k == 0);
                    e.lk = (k == t.k - 1);
                    exp_q.push_back(e);
                end
    endtask

    task automatic run_vec(input vec_t t, input string name);
        int n;
        int beats;
        int stall_cnt;
        bit got_done;
        exp_q.delete();
        push_model(t);
        @(negedge clock);
        sel        = (t.sel != 0);
        dim_i      = 8'(t.i);
        dim_j      = 8'(t.j);
        dim_k      = 8'(t.k);
        base_a     = 8'(t.ba);
        base_b     = 8'(t.bb);
        base_d     = 8'(t.bd);
        b_trans    = (t.bt != 0);
        core_id    = 1'(t.cid);
        addr_ready = 1'b1;
        start      = 1'b1;
        @(negedge clock);
        // Scramble the job inputs: the DUT must work from its latched copy.
        start   = 1'b0;
        dim_i   = 8'($urandom);
        dim_j   = 8'($urandom);
        dim_k   = 8'($urandom);
        base_a  = 8'($urandom);
        base_b  = 8'($urandom);
        base_d  = 8'($urandom);
        b_trans = 1'($urandom);
        core_id = 1'($urandom);
        check({name, "_setup"}, {o_busy, o_v, o_done}, 3'b100);
        beats     = 0;
        stall_cnt = 0;
        got_done  = 0;
        for (n = 1; n < 400; n++) begin
            if (n > 1) @(negedge clock);
            start      = (n == t.pulse_at);
            addr_ready = !(beats == t.stall_at && stall_cnt < t.stall_len);
            if (o_v) begin
                if (exp_q.size() == 0) begin
                    check({name, "_extra_beat"}, 64'(beats), 64'(t.exp_beats));
                end else begin
                    check({name, "_beat"}, {o_a, o_b, o_d, o_fk, o_lk},
                          {exp_q[0].a, exp_q[0].b, exp_q[0].d, exp_q[0].fk, exp_q[0].lk});
                    if (addr_ready) begin
                        void'(exp_q.pop_front());
                        beats++;
                    end else begin
                        stall_cnt++;
                    end
                end
            end
            if (o_done) begin
                got_done = 1;
                break;
            end
        end
        start      = 1'b0;
        addr_ready = 1'b1;
        check({name, "_done_latency"}, got_done ? 64'(n) : 64'hffff, 64'(t.exp_lat));
        check({name, "_beat_count"}, 64'(beats), 64'(t.exp_beats));
        check({name, "_leftover"}, 64'(exp_q.size()), 64'd0);
        @(negedge clock);
        check({name, "_idle_after"}, {o_done, o_busy, o_v}, 3'b000);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        RST        = 1'b1;
        start      = 1'b0;
        sel        = 1'b0;
        dim_i      = '0;
        dim_j      = '0;
        dim_k      = '0;
        base_a     = '0;
        base_b     = '0;
        base_d     = '0;
        b_trans    = 1'b0;
        core_id    = '0;
        addr_ready = 1'b1;

        //          sel i j k  ba   bb   bd  bt cid st sl pulse beats lat
        vecs[0]  = '{0, 2, 2, 2, 0,   16,  32,  0, 0, -1, 0, 0, 8,  10};
        vecs[1]  = '{0, 2, 2, 2, 0,   16,  32,  1, 0, -1, 0, 0, 8,  10};
        vecs[2]  = '{1, 3, 1, 1, 0,   8,   20,  0, 1, -1, 0, 0, 1,  3};
        vecs[3]  = '{1, 3, 1, 1, 0,   8,   20,  0, 0, -1, 0, 0, 2,  4};
        vecs[4]  = '{0, 2, 2, 2, 0,   16,  32,  0, 0, 2,  3, 0, 8,  13};
        vecs[5]  = '{0, 2, 2, 0, 0,   16,  32,  0, 0, -1, 0, 0, 0,  2};
        vecs[6]  = '{0, 1, 1, 3, 5,   6,   7,   0, 0, -1, 0, 3, 3,  5};
        vecs[7]  = '{0, 1, 1, 4, 254, 0,   0,   0, 0, -1, 0, 0, 4,  6};
        vecs[8]  = '{0, 3, 2, 3, 100, 200, 50,  1, 0, -1, 0, 0, 18, 20};
        vecs[9]  = '{1, 5, 2, 2, 250, 3,   240, 0, 1, -1, 0, 0, 8,  10};
        vecs[10] = '{0, 0, 3, 3, 1,   2,   3,   0, 0, -1, 0, 0, 0,  2};
        vecs[11] = '{1, 1, 2, 2, 1,   2,   3,   0, 1, -1, 0, 0, 0,  2};

        repeat (3) @(negedge clock);
        check("reset_dut1", {v1, a1, b1, d1, fk1, lk1, busy1, done1}, 64'd0);
        check("reset_dut2", {v2, a2, b2, d2, fk2, lk2, busy2, done2}, 64'd0);
        RST = 1'b0;

        for (int v = 0; v < 12; v++) begin
            run_vec(vecs[v], $sformatf("vec%0d", v));
        end

        // Reset in the middle of a job: outputs clear at once, no done, IDLE afterwards.
        @(negedge clock);
        sel     = 1'b0;
        dim_i   = 8'd1;
        dim_j   = 8'd1;
        dim_k   = 8'd4;
        base_a  = 8'd254;
        base_b  = 8'd0;
        base_d  = 8'd0;
        b_trans = 1'b0;
        core_id = '0;
        start   = 1'b1;
        @(negedge clock);
        start = 1'b0;
        repeat (2) @(negedge clock);
        check("rst_pre_valid", {o_v, o_a}, {1'b1, 8'd255});
        RST = 1'b1;
        #1;
        check("rst_async_clear", {v1, a1, b1, d1, fk1, lk1, busy1, done1}, 64'd0);
        @(negedge clock);
        RST = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clock);
            check($sformatf("rst_after_idle%0d", c), {o_v, o_busy, o_done}, 3'b000);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
